fcvt_int: RTL and testbench



---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fp_classify.sv | 38 +++
 rtl/fcvt_int.sv | 212 +++++++++++++++++++++
 tb/tb_fcvt_int.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, fflags bit positions and
// width-keyed IEEE-754 format constants used by the int<->float converters.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ROUND,
    ST_DONE
  } cvt_state_e;

  function automatic int mantissa_size(input int bus_width);
    return (bus_width == 64) ? 52 : 23;
  endfunction

  function automatic int exponent_size(input int bus_width);
    return (bus_width == 64) ? 11 : 8;
  endfunction

  function automatic int bias(input int bus_width);
    return (bus_width == 64) ? 1023 : 127;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier (single when BUS_WIDTH=32,
// double when BUS_WIDTH=64).
module fp_classify
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] in1,
  output logic                 is_nan,
  output logic                 is_inf,
  output logic                 is_zero,
  output logic                 is_subnormal
);

  localparam int MS = mantissa_size(BUS_WIDTH);
  localparam int ES = exponent_size(BUS_WIDTH);

  logic [ES-1:0] exp_f;
  logic [MS-1:0] frac_f;
  logic          exp_ones;
  logic          exp_zero;
  logic          frac_zero;
  logic          unused_sign;

  assign exp_f       = in1[BUS_WIDTH-2 -: ES];
  assign frac_f      = in1[MS-1:0];
  assign unused_sign = in1[BUS_WIDTH-1];

  assign exp_ones  = &exp_f;
  assign exp_zero  = ~|exp_f;
  assign frac_zero = ~|frac_f;

  assign is_nan       = exp_ones & ~frac_zero;
  assign is_inf       = exp_ones & frac_zero;
  assign is_zero      = exp_zero & frac_zero;
  assign is_subnormal = exp_zero & ~frac_zero;

endmodule

// File: rtl/fcvt_int.sv
// Multi-cycle float-to-integer converter (FCVT.W[U].S / FCVT.L[U].D) with
// IEEE rounding, saturation and NV/NX flag generation.
module fcvt_int
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [2:0]           rm,
  input  logic                 is_unsigned,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic [4:0]           fflags
);

  localparam int W    = BUS_WIDTH;
  localparam int MW   = W + 1;
  localparam int MS   = mantissa_size(W);
  localparam int ES   = exponent_size(W);
  localparam int BIAS = bias(W);
  localparam int FW   = MS + 1;
  localparam int XW   = W + 1 + FW;

  function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
    return inc;
  endfunction

  // Returns {fflags, value}; the signed-min exact case is the only
  // negative magnitude of 2^(W-1) that is representable.
  function automatic logic [W+4:0] saturate(input logic sign, input logic uns,
                                            input logic nan, input logic inf,
                                            input logic huge, input logic [W:0] mag,
                                            input logic inexact);
    logic [W-1:0] smax;
    logic [W-1:0] smin;
    logic [W-1:0] ones;
    logic [W-1:0] v;
    logic [4:0]   fl;
    logic         nv;
    smax = {1'b0, {(W-1){1'b1}}};
    smin = {1'b1, {(W-1){1'b0}}};
    ones = '1;
    v    = '0;
    nv   = 1'b0;
    fl   = '0;
    if (nan) begin
      nv = 1'b1;
      v  = uns ? ones : smax;
    end else if (inf | huge) begin
      nv = 1'b1;
      if (sign) v = uns ? '0 : smin;
      else      v = uns ? ones : smax;
    end else if (uns) begin
      if (sign) begin
        nv = |mag;
      end else if (mag[W]) begin
        nv = 1'b1;
        v  = ones;
      end else begin
        v = mag[W-1:0];
      end
    end else if (!sign) begin
      if (mag[W] | mag[W-1]) begin
        nv = 1'b1;
        v  = smax;
      end else begin
        v = mag[W-1:0];
      end
    end else begin
      if (mag[W] | (mag[W-1] & (|mag[W-2:0]))) begin
        nv = 1'b1;
        v  = smin;
      end else begin
        v = -mag[W-1:0];
      end
    end
    fl[FLAG_NV] = nv;
    fl[FLAG_NX] = inexact & ~nv;
    return {fl, v};
  endfunction

  cvt_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_ALIGN;
      ST_ALIGN: state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // p0: operand capture in IDLE
  logic [W-1:0] op_p0;
  logic [2:0]   rm_p0;
  logic         uns_p0;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      op_p0  <= in1;
      rm_p0  <= rm;
      uns_p0 <= is_unsigned;
    end
  end

  logic is_nan, is_inf, is_zero, is_subnormal;

  fp_classify #(.BUS_WIDTH(W)) u_classify (
    .in1          (op_p0),
    .is_nan       (is_nan),
    .is_inf       (is_inf),
    .is_zero      (is_zero),
    .is_subnormal (is_subnormal)
  );

  logic [ES-1:0] exp_a;
  logic [MS:0]   sig_a;
  int            e_a;
  logic [7:0]    sh_a;
  logic [XW-1:0] fx_a;
  logic [W:0]    mag_a;
  logic          g_a, s_a, huge_a;

  // Fixed-point view with FW fraction bits: sig * 2^(e-MS) == sig << (e+1).
  always_comb begin
    exp_a  = op_p0[W-2 -: ES];
    sig_a  = {~(is_zero | is_subnormal), op_p0[MS-1:0]};
    e_a    = int'(exp_a) - BIAS;
    sh_a   = '0;
    fx_a   = '0;
    mag_a  = '0;
    g_a    = 1'b0;
    s_a    = 1'b0;
    huge_a = 1'b0;
    if (is_nan | is_inf) begin
      huge_a = 1'b0;
    end else if (e_a >= W) begin
      huge_a = 1'b1;
    end else if (e_a < -1) begin
      s_a = ~is_zero;
    end else begin
      sh_a  = 8'(e_a + 1);
      fx_a  = XW'(sig_a) << sh_a;
      mag_a = fx_a[XW-1:FW];
      g_a   = fx_a[FW-1];
      s_a   = |fx_a[FW-2:0];
    end
  end

  // p1: aligned magnitude, guard/sticky and class, registered in ALIGN
  logic         sign_p1, nan_p1, inf_p1, huge_p1, g_p1, s_p1;
  logic [W:0]   mag_p1;

  always_ff @(posedge clk) begin
    if (state == ST_ALIGN) begin
      sign_p1 <= op_p0[W-1];
      nan_p1  <= is_nan;
      inf_p1  <= is_inf;
      huge_p1 <= huge_a;
      mag_p1  <= mag_a;
      g_p1    <= g_a;
      s_p1    <= s_a;
    end
  end

  logic           inc_r;
  logic [W:0]     mag_r;
  logic [W+4:0]   res_r;

  always_comb begin
    inc_r = round_inc(rm_p0, sign_p1, mag_p1[0], g_p1, s_p1);
    mag_r = mag_p1 + MW'(inc_r);
    res_r = saturate(sign_p1, uns_p0, nan_p1, inf_p1, huge_p1, mag_r, g_p1 | s_p1);
  end

  // p2: rounded, saturated result held through DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out    <= '0;
      fflags <= '0;
    end else if (state == ST_ROUND) begin
      {fflags, out} <= res_r;
    end
  end

endmodule

// File: tb/tb_fcvt_int.sv
// Directed bench for fcvt_int: 64-bit and 32-bit instances, rounding,
// saturation, handshake back-pressure and mid-operation reset.
module tb_fcvt_int;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ordy;

  logic        iv64, ir64, u64, ov64;
  logic [63:0] a64, o64;
  logic [2:0]  rm64;
  logic [4:0]  f64;

  logic        iv32, ir32, u32, ov32;
  logic [31:0] a32, o32;
  logic [2:0]  rm32;
  logic [4:0]  f32;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is32;
    logic [63:0] v;
    logic [2:0]  m;
    bit          u;
    logic [63:0] eo;
    logic [4:0]  ef;
  } vec_t;

  always #5 clk = ~clk;

  fcvt_int #(.BUS_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .in1(a64),
    .rm(rm64), .is_unsigned(u64), .out_valid(ov64), .out_ready(ordy),
    .out(o64), .fflags(f64)
  );

  fcvt_int #(.BUS_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in1(a32),
    .rm(rm32), .is_unsigned(u32), .out_valid(ov32), .out_ready(ordy),
    .out(o32), .fflags(f32)
  );

  task automatic convert(input bit is32, input logic [63:0] v, input logic [2:0] m,
                         input bit u, output logic [63:0] r, output logic [4:0] f,
                         output int lat);
    @(negedge clk);
    if (is32) begin a32 = v[31:0]; rm32 = m; u32 = u; iv32 = 1'b1; end
    else      begin a64 = v;       rm64 = m; u64 = u; iv64 = 1'b1; end
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    r = 'x; f = 'x; lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (is32 ? ov32 : ov64) begin
        r   = is32 ? {32'h0, o32} : o64;
        f   = is32 ? f32 : f64;
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0 && ordy) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ir64 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir64); end
    n_cmp++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov64); end
    n_cmp++; if (o64 !== 64'h0) begin n_fail++; $display("FAIL reset_out got %h want 0", o64); end
    n_cmp++; if (f64 !== 5'h0) begin n_fail++; $display("FAIL reset_fflags got %h want 0", f64); end
    n_cmp++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin n_fail++; $display("FAIL reset_32 got ov=%b ir=%b want 0/1", ov32, ir32); end
    rst_n = 1'b1;
  endtask

  task automatic test_rounding();
    vec_t tv[9];
    logic [63:0] r;
    logic [4:0]  f;
    int          lat;
    tv = '{
      '{0, 64'h3FF8000000000000, 3'b000, 0, 64'd2, 5'h01},
      '{0, 64'h3FF8000000000000, 3'b001, 0, 64'd1, 5'h01},
      '{0, 64'h4004000000000000, 3'b000, 0, 64'd2, 5'h01},
      '{0, 64'h4004000000000000, 3'b100, 0, 64'd3, 5'h01},
      '{0, 64'h4004000000000000, 3'b011, 0, 64'd3, 5'h01},
      '{0, 64'h4004000000000000, 3'b010, 0, 64'd2, 5'h01},
      '{0, 64'h4004000000000000, 3'b111, 0, 64'd2, 5'h01},
      '{0, 64'hC004000000000000, 3'b010, 0, 64'hFFFFFFFFFFFFFFFD, 5'h01},
      '{0, 64'h43DFFFFFFFFFFFFF, 3'b000, 0, 64'h7FFFFFFFFFFFFC00, 5'h00}
    };
    for (int i = 0; i < 9; i++) begin
      convert(tv[i].is32, tv[i].v, tv[i].m, tv[i].u, r, f, lat);
      n_cmp++; if (r !== tv[i].eo) begin n_fail++; $display("FAIL round_out[%0d] got %h want %h", i, r, tv[i].eo); end
      n_cmp++; if (f !== tv[i].ef) begin n_fail++; $display("FAIL round_flags[%0d] got %h want %h", i, f, tv[i].ef); end
      if (i == 0) begin
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL latency got %0d want 2", lat); end
      end
    end
  endtask

  task automatic test_saturation();
    vec_t tv[12];
    logic [63:0] r;
    logic [4:0]  f;
    int          lat;
    tv = '{
      '{0, 64'hBFF0000000000000, 3'b000, 1, 64'h0, 5'h10},
      '{0, 64'hBFD0000000000000, 3'b001, 1, 64'h0, 5'h01},
      '{0, 64'h0000000000000001, 3'b011, 0, 64'd1, 5'h01},
      '{0, 64'h43F0000000000000, 3'b000, 1, 64'hFFFFFFFFFFFFFFFF, 5'h10},
      '{0, 64'h7FF8000000000000, 3'b000, 0, 64'h7FFFFFFFFFFFFFFF, 5'h10},
      '{0, 64'hFFF8000000000000, 3'b000, 1, 64'hFFFFFFFFFFFFFFFF, 5'h10},
      '{0, 64'hFFF0000000000000, 3'b000, 0, 64'h8000000000000000, 5'h10},
      '{0, 64'hC3E0000000000000, 3'b000, 0, 64'h8000000000000000, 5'h00},
      '{0, 64'h43E0000000000000, 3'b000, 0, 64'h7FFFFFFFFFFFFFFF, 5'h10},
      '{0, 64'h8000000000000000, 3'b011, 0, 64'h0, 5'h00},
      '{0, 64'h0000000000000000, 3'b000, 1, 64'h0, 5'h00},
      '{0, 64'hC3F0000000000000, 3'b000, 0, 64'h8000000000000000, 5'h10}
    };
    for (int i = 0; i < 12; i++) begin
      convert(tv[i].is32, tv[i].v, tv[i].m, tv[i].u, r, f, lat);
      n_cmp++; if (r !== tv[i].eo) begin n_fail++; $display("FAIL sat_out[%0d] got %h want %h", i, r, tv[i].eo); end
      n_cmp++; if (f !== tv[i].ef) begin n_fail++; $display("FAIL sat_flags[%0d] got %h want %h", i, f, tv[i].ef); end
    end
  endtask

  task automatic test_w32();
    vec_t tv[5];
    logic [63:0] r;
    logic [4:0]  f;
    int          lat;
    tv = '{
      '{1, 64'h4F000000, 3'b000, 0, 64'h7FFFFFFF, 5'h10},
      '{1, 64'h4F000000, 3'b000, 1, 64'h80000000, 5'h00},
      '{1, 64'h3FC00000, 3'b000, 0, 64'h2, 5'h01},
      '{1, 64'hBFC00000, 3'b000, 0, 64'hFFFFFFFE, 5'h01},
      '{1, 64'hCF000000, 3'b001, 0, 64'h80000000, 5'h00}
    };
    for (int i = 0; i < 5; i++) begin
      convert(tv[i].is32, tv[i].v, tv[i].m, tv[i].u, r, f, lat);
      n_cmp++; if (r !== tv[i].eo) begin n_fail++; $display("FAIL w32_out[%0d] got %h want %h", i, r, tv[i].eo); end
      n_cmp++; if (f !== tv[i].ef) begin n_fail++; $display("FAIL w32_flags[%0d] got %h want %h", i, f, tv[i].ef); end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    @(negedge clk);
    ordy = 1'b0;
    a64 = 64'h3FF8000000000000; rm64 = 3'b000; u64 = 1'b0; iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ov64) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got %b want 1", seen); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (ov64 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got %b want 1", j, ov64); end
      n_cmp++; if (o64 !== 64'd2 || f64 !== 5'h01) begin n_fail++; $display("FAIL bp_hold_data[%0d] got %h/%h want 2/01", j, o64, f64); end
      n_cmp++; if (ir64 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", j, ir64); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", ov64); end
    n_cmp++; if (ir64 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", ir64); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] r;
    logic [4:0]  f;
    int          lat;
    @(negedge clk);
    a64 = 64'hC004000000000000; rm64 = 3'b010; u64 = 1'b0; iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", ov64); end
    n_cmp++; if (ir64 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", ir64); end
    n_cmp++; if (o64 !== 64'h0) begin n_fail++; $display("FAIL midrst_out got %h want 0", o64); end
    rst_n = 1'b1;
    convert(1'b0, 64'h4004000000000000, 3'b100, 1'b0, r, f, lat);
    n_cmp++; if (r !== 64'd3) begin n_fail++; $display("FAIL midrst_next_out got %h want 3", r); end
    n_cmp++; if (f !== 5'h01) begin n_fail++; $display("FAIL midrst_next_flags got %h want 01", f); end
  endtask

  initial begin
    rst_n = 1'b0; ordy = 1'b1;
    iv64 = 1'b0; a64 = '0; rm64 = '0; u64 = 1'b0;
    iv32 = 1'b0; a32 = '0; rm32 = '0; u32 = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_w32();
    test_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
